// File: rtl/conv2d_pkg.sv
// Shared definitions for the output BRAM-to-AXI-Stream block:
// default bus widths and the 3-bit FSM state encoding.
package conv2d_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_ADDR_WIDTH = 10;

   typedef enum logic [2:0] {
      S_Reset  = 3'd0,
      S_Idle   = 3'd1,
      S_Stream = 3'd2,
      S_Done   = 3'd3
   } state_t;

endpackage

// File: rtl/output_bram_axis_tx_if.sv
// AXI-Stream master bus (tdata/tvalid/tlast/tready) bundled for the
// transmitter; the master modport is the block, the slave is the sink.
interface output_bram_axis_tx_if
   import conv2d_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/axis_fifo2.sv
// Two-entry FIFO holding BRAM read data until the stream sink takes it.
// Exposes only occupancy and head; the producer is expected to throttle
// itself from the count, so push into a full FIFO is dropped defensively.
module axis_fifo2
   import conv2d_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   output logic [1:0]            count,
   output logic [DATA_WIDTH-1:0] head
);

   localparam logic [1:0] COUNT_ONE = 2'd1;

   logic [DATA_WIDTH-1:0] mem_reg [2];
   logic                  wr_ptr_reg;
   logic                  rd_ptr_reg;
   logic [1:0]            count_reg;
   logic                  pop_ok;
   logic                  push_ok;

   assign pop_ok  = pop && (count_reg != 2'd0);
   assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

   // Storage, pointers and occupancy; storage is cleared so head reads 0 after reset
   always_ff @(posedge clk) begin
      if (srst) begin
         for (int i = 0; i < 2; i++) begin
            mem_reg[i] <= '0;
         end
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_reg[wr_ptr_reg] <= din;
            wr_ptr_reg          <= ~wr_ptr_reg;
         end
         if (pop_ok) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + COUNT_ONE;
            2'b01:   count_reg <= count_reg - COUNT_ONE;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign count = count_reg;
   assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/output_bram_axis_tx.sv
// Streams NUM_WORDS words from BRAM port B (1-cycle read latency) onto an
// AXI-Stream master. Reads are throttled so that FIFO contents plus the
// read in flight never exceed two words; the sink may stall at any time.
module output_bram_axis_tx
   import conv2d_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   Reset,
   input  logic                   start,
   input  logic [ADDR_WIDTH:0]    NUM_WORDS,
   output logic                   enb,
   output logic [ADDR_WIDTH-1:0]  addrb,
   input  logic [DATA_WIDTH-1:0]  doutb,
   output_bram_axis_tx_if.master  m_axis,
   output logic                   busy,
   output logic                   done
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

   state_t                state_reg;
   logic [ADDR_WIDTH:0]   num_words_reg;
   logic [ADDR_WIDTH:0]   issued_reg;
   logic [ADDR_WIDTH:0]   sent_reg;
   logic [ADDR_WIDTH-1:0] rd_addr_reg;
   logic                  inflight_reg;
   logic                  busy_reg;
   logic                  done_reg;

   logic [1:0]            fifo_count;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  fifo_srst;
   logic                  tvalid;
   logic                  pop;
   logic                  last_beat;
   logic [2:0]            level;
   logic                  has_room;
   logic                  issue;

   // A word is presented whenever the FIFO holds one; a beat leaves on handshake
   assign tvalid    = (fifo_count != 2'd0);
   assign pop       = tvalid & m_axis.tready;
   assign last_beat = (sent_reg == (num_words_reg - CNT_ONE));

   // Words already committed (buffered or in flight) minus the one leaving now
   assign level    = {1'b0, fifo_count} + {2'b00, inflight_reg};
   assign has_room = (level <= (3'd1 + {2'b00, pop}));
   assign issue    = (state_reg == S_Stream) && (issued_reg < num_words_reg) && has_room;

   // Address is forced to zero on idle cycles so the BRAM port sees a clean bus
   assign enb   = issue;
   assign addrb = issue ? rd_addr_reg : '0;

   assign m_axis.tvalid = tvalid;
   assign m_axis.tdata  = fifo_head;
   assign m_axis.tlast  = tvalid & last_beat;

   assign busy = busy_reg;
   assign done = done_reg;

   assign fifo_srst = ~Reset;

   axis_fifo2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .srst  (fifo_srst),
      .push  (inflight_reg),
      .din   (doutb),
      .pop   (pop),
      .count (fifo_count),
      .head  (fifo_head)
   );

   // Control FSM with read/sent counters; busy and done are registered alongside the state
   always_ff @(posedge clk) begin
      if (!Reset) begin
         state_reg     <= S_Reset;
         num_words_reg <= '0;
         issued_reg    <= '0;
         sent_reg      <= '0;
         rd_addr_reg   <= '0;
         inflight_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         // Data for a read issued this cycle arrives on doutb next cycle
         inflight_reg <= issue;
         if (issue) begin
            rd_addr_reg <= rd_addr_reg + ADDR_ONE;
            issued_reg  <= issued_reg + CNT_ONE;
         end
         if (pop) begin
            sent_reg <= sent_reg + CNT_ONE;
         end

         case (state_reg)
            S_Reset: begin
               state_reg <= S_Idle;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
            S_Idle: begin
               if (start) begin
                  num_words_reg <= NUM_WORDS;
                  issued_reg    <= '0;
                  sent_reg      <= '0;
                  rd_addr_reg   <= '0;
                  busy_reg      <= 1'b1;
                  if (NUM_WORDS == '0) begin
                     state_reg <= S_Done;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= S_Stream;
                  end
               end
            end
            S_Stream: begin
               if (pop && last_beat) begin
                  state_reg <= S_Done;
                  done_reg  <= 1'b1;
               end
            end
            S_Done: begin
               state_reg <= S_Idle;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
            default: begin
               state_reg <= S_Reset;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_output_bram_axis_tx.sv
// Directed bench for output_bram_axis_tx with ADDR_WIDTH=4: a table of
// block transfers (word count, BRAM pattern, sink ready pattern, expected
// done cycle) plus a hand-written mid-stream reset sequence.
module tb_output_bram_axis_tx;

   localparam int DW = 32;
   localparam int AW = 4;

   typedef struct {
      int          n;
      logic [31:0] base;
      int          mode;       // 0: tready always 1, 1: tready 1,0,0 repeating
      bit          start_mid;  // pulse start again while streaming
      int          exp_done;   // cycle index (after accepting edge) of done
      string       name;
   } vec_t;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic [AW:0]   num_words;
   logic          enb;
   logic [AW-1:0] addrb;
   logic [DW-1:0] doutb;
   logic          busy;
   logic          done;
   logic [DW-1:0] bram [16];

   int compared;
   int mismatched;

   output_bram_axis_tx_if #(.DATA_WIDTH(DW)) m_axis_if ();

   output_bram_axis_tx #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk       (clk),
      .Reset     (reset_n),
      .start     (start),
      .NUM_WORDS (num_words),
      .enb       (enb),
      .addrb     (addrb),
      .doutb     (doutb),
      .m_axis    (m_axis_if),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model, one-cycle registered read
   always @(posedge clk) begin
      if (enb) doutb <= bram[addrb];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic ready_of(input int mode, input int k);
      return (mode == 0) ? 1'b1 : ((k % 3) == 0);
   endfunction

   task automatic run_vec(input vec_t v);
      int          reads;
      int          sent;
      int          first_tv;
      int          done_k;
      int          occ;
      logic        tv, tl, en, bs, dn, rdy;
      logic        prev_tv, prev_rdy, prev_tl;
      logic [31:0] td, prev_td;
      logic [3:0]  ad;
      for (int i = 0; i < 16; i++) bram[i] = v.base + 32'(i);
      reads = 0; sent = 0; first_tv = -1; done_k = -1;
      prev_tv = 1'b0; prev_rdy = 1'b0; prev_tl = 1'b0; prev_td = '0;
      @(negedge clk);
      start = 1'b1;
      num_words = 5'(v.n);
      m_axis_if.tready = ready_of(v.mode, 0);
      for (int k = 1; k <= 60 && done_k < 0; k++) begin
         @(negedge clk);
         start = v.start_mid && (k == 2);
         num_words = 5'd3;
         rdy = ready_of(v.mode, k);
         m_axis_if.tready = rdy;
         #1;
         tv = m_axis_if.tvalid; td = m_axis_if.tdata; tl = m_axis_if.tlast;
         en = enb; ad = addrb; bs = busy; dn = done;
         occ = reads - sent;
         check("occupancy_le2", 32'(occ <= 2), 32'd1);
         if (prev_tv && !prev_rdy) begin
            check("stall_valid", tv, 1);
            check("stall_data", td, prev_td);
            check("stall_last", tl, prev_tl);
         end
         if (k == 1) check("first_read_cycle", en, 32'(v.n != 0));
         if (en) begin
            check("read_addr", ad, 32'(reads));
            check("read_in_range", 32'(reads < v.n), 32'd1);
            reads++;
         end else begin
            check("addrb_idle", ad, 0);
         end
         if (tv && first_tv < 0) begin
            first_tv = k;
            check("first_valid_cycle", k, 3);
         end
         if (!tv) check("tlast_idle", tl, 0);
         if (tv && rdy) begin
            check("beat_data", td, v.base + 32'(sent));
            check("beat_last", tl, 32'(sent == v.n - 1));
            if (v.mode == 0) check("beat_cycle", k, 32'(3 + sent));
            sent++;
         end
         check("busy_active", bs, 1);
         if (dn) begin
            done_k = k;
            check("done_cycle", k, v.exp_done);
         end
         prev_tv = tv; prev_rdy = rdy; prev_td = td; prev_tl = tl;
      end
      check("done_seen", 32'(done_k >= 0), 32'd1);
      check("beat_total", sent, v.n);
      check("read_total", reads, v.n);
      if (v.n == 0) check("no_valid", 32'(first_tv < 0), 32'd1);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         #1;
         check("post_done", done, 0);
         check("post_busy", busy, 0);
         check("post_valid", m_axis_if.tvalid, 0);
      end
      $display("block %s: n=%0d beats=%0d reads=%0d done_cycle=%0d", v.name, v.n, sent, reads, done_k);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tvalid"}, m_axis_if.tvalid, 0);
      check({tag, "_tlast"}, m_axis_if.tlast, 0);
      check({tag, "_tdata"}, m_axis_if.tdata, 0);
      check({tag, "_enb"}, enb, 0);
      check({tag, "_addrb"}, addrb, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   vec_t vecs[5];
   vec_t tail;
   int   beats;

   initial begin
      compared = 0;
      mismatched = 0;
      reset_n = 1'b0;
      start = 1'b0;
      num_words = '0;
      m_axis_if.tready = 1'b0;

      vecs[0] = '{4,  32'h0000_00A0, 0, 1'b0, 7,  "burst4"};
      vecs[1] = '{6,  32'h0000_00B0, 1, 1'b0, 19, "stall6"};
      vecs[2] = '{0,  32'h0000_0000, 0, 1'b0, 1,  "empty"};
      vecs[3] = '{1,  32'h0000_00C0, 0, 1'b1, 4,  "single_restart"};
      vecs[4] = '{16, 32'h0000_0100, 0, 1'b0, 19, "full16"};
      tail    = '{2,  32'h0000_0050, 0, 1'b0, 5,  "after_reset"};

      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 5; v++) run_vec(vecs[v]);

      // Abort an 8-word block after beat 2 with a reset
      for (int i = 0; i < 16; i++) bram[i] = 32'h0000_00D0 + 32'(i);
      @(negedge clk);
      start = 1'b1;
      num_words = 5'd8;
      m_axis_if.tready = 1'b1;
      beats = 0;
      for (int k = 1; k <= 20 && beats < 3; k++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (m_axis_if.tvalid) begin
            check("abort_beat_data", m_axis_if.tdata, 32'h0000_00D0 + 32'(beats));
            beats++;
         end
      end
      check("abort_beats_before_reset", beats, 3);
      reset_n = 1'b0;
      @(negedge clk);
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         #1;
         check("no_resume_valid", m_axis_if.tvalid, 0);
         check("no_resume_enb", enb, 0);
         check("no_resume_busy", busy, 0);
      end
      $display("block abort8: beats before reset=%0d", beats);

      run_vec(tail);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
